// File: rtl/addsat_pipe_if.sv
// Operand/result bundle for addsat_pipe: input beat handshake, result
// handshake and saturation status. Clock and reset stay outside.
interface addsat_pipe_if #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8,
    parameter int CNTW  = 16
);
    localparam int NL = WIDTH / LANE;

    // operand beat
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sat;
    logic             split;

    // result beat
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             co;
    logic [NL-1:0]    satflag;

    // status
    logic             clr_status;
    logic [NL-1:0]    sat_sticky;
    logic [CNTW-1:0]  sat_count;

    // producer / consumer side (testbench, upstream fetch + writeback)
    modport master (
        output in_valid, a, b, cin, sat, split, out_ready, clr_status,
        input  in_ready, out_valid, r, co, satflag, sat_sticky, sat_count
    );

    // adder side
    modport slave (
        input  in_valid, a, b, cin, sat, split, out_ready, clr_status,
        output in_ready, out_valid, r, co, satflag, sat_sticky, sat_count
    );
endinterface

// File: rtl/addsat_pipe.sv
// Pipelined saturating adder: unsigned a + signed delta b, clamped to
// [0, all-ones], either as one WIDTH-bit word or NL independent lanes.
// S1 holds the raw sum, S2 holds the saturated result. WIDTH must be a
// multiple of LANE.

// One lane slice. The add half feeds S1, the clamp half works on the S2
// copy of that lane. In full-word mode the caller hands the word-level
// carry/sign in as s_c/s_bs so every lane clamps the same way.
module addsat_lane #(
    parameter int LANE = 8
) (
    // add half (combinational, ahead of S1)
    input  logic            ci,
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    output logic [LANE-1:0] q,
    output logic            c,
    // clamp half (combinational, ahead of S2)
    input  logic [LANE-1:0] s_q,
    input  logic            s_c,
    input  logic            s_bs,
    input  logic            s_sat,
    output logic [LANE-1:0] s_r,
    output logic            s_flag
);
    logic ovf;

    // raw lane sum with carry out
    assign {c, q} = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, ci};

    // carry disagreeing with the delta sign means the true result left
    // [0, all-ones]; the carry itself says which end to clamp to
    assign ovf    = s_c ^ s_bs;
    assign s_flag = s_sat & ovf;
    assign s_r    = s_flag ? {LANE{s_c}} : s_q;
endmodule

module addsat_pipe #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8,
    parameter int CNTW  = 16
) (
    input logic         clk,
    input logic         reset,
    addsat_pipe_if.slave bus
);
    localparam int NL = WIDTH / LANE;

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic adv1;
    logic adv2;
    logic s1_valid;
    logic s2_valid;

    assign adv2        = ~s2_valid | bus.out_ready;
    assign adv1        = ~s1_valid | adv2;
    assign bus.in_ready = adv1;

    // ---------------------------------------------------------------
    // Lane datapath
    // ---------------------------------------------------------------
    logic [NL-1:0]    lane_ci;   // carry into each lane
    logic [WIDTH-1:0] sum_q;     // raw sum, all lanes
    logic [NL-1:0]    sum_c;     // raw carry out of each lane
    logic [NL-1:0]    sum_bs;    // delta sign bit of each lane

    logic [WIDTH-1:0] s1_q;
    logic [NL-1:0]    s1_c;
    logic [NL-1:0]    s1_bs;
    logic             s1_sat;
    logic             s1_split;

    logic [WIDTH-1:0] clamp_r;
    logic [NL-1:0]    clamp_f;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic lc;
        logic lbs;

        // lane 0 always takes cin; the others chain only in full-word mode
        if (i == 0) begin : g_c0
            assign lane_ci[i] = bus.cin;
        end else begin : g_cn
            assign lane_ci[i] = sum_c[i-1] & ~bus.split;
        end

        assign sum_bs[i] = bus.b[i*LANE + LANE-1];

        // full-word mode clamps every lane off the top-lane carry/sign
        assign lc  = s1_split ? s1_c[i]  : s1_c[NL-1];
        assign lbs = s1_split ? s1_bs[i] : s1_bs[NL-1];

        addsat_lane #(.LANE(LANE)) u_lane (
            .ci     (lane_ci[i]),
            .a      (bus.a[i*LANE +: LANE]),
            .b      (bus.b[i*LANE +: LANE]),
            .q      (sum_q[i*LANE +: LANE]),
            .c      (sum_c[i]),
            .s_q    (s1_q[i*LANE +: LANE]),
            .s_c    (lc),
            .s_bs   (lbs),
            .s_sat  (s1_sat),
            .s_r    (clamp_r[i*LANE +: LANE]),
            .s_flag (clamp_f[i])
        );
    end

    // ---------------------------------------------------------------
    // S1: raw sum plus the mode bits that travel with the beat
    // ---------------------------------------------------------------
    // S1 register; payload only loads on an accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_c     <= '0;
            s1_bs    <= '0;
            s1_sat   <= 1'b0;
            s1_split <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q     <= sum_q;
                s1_c     <= sum_c;
                s1_bs    <= sum_bs;
                s1_sat   <= bus.sat;
                s1_split <= bus.split;
            end
        end
    end

    // ---------------------------------------------------------------
    // S2: clamped result, held while the consumer stalls
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] r_q;
    logic             co_q;
    logic [NL-1:0]    flag_q;

    // S2 register; co is the raw top carry regardless of sat/split
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            r_q      <= '0;
            co_q     <= 1'b0;
            flag_q   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                r_q    <= clamp_r;
                co_q   <= s1_c[NL-1];
                flag_q <= clamp_f;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.r         = r_q;
    assign bus.co        = co_q;
    assign bus.satflag   = flag_q;

    // ---------------------------------------------------------------
    // Status: sticky flags and event counter, recorded on transfer
    // ---------------------------------------------------------------
    logic            xfer;
    logic            evt;
    logic [NL-1:0]   sticky_q;
    logic [CNTW-1:0] count_q;

    assign xfer = s2_valid & bus.out_ready;
    assign evt  = |flag_q;

    // clear wins over history but the beat transferring this cycle still counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
            count_q  <= '0;
        end else if (bus.clr_status) begin
            sticky_q <= xfer ? flag_q : '0;
            count_q  <= {{(CNTW-1){1'b0}}, xfer & evt};
        end else if (xfer) begin
            sticky_q <= sticky_q | flag_q;
            if (evt && (count_q != {CNTW{1'b1}}))
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.sat_sticky = sticky_q;
    assign bus.sat_count  = count_q;
endmodule

// File: tb/tb_addsat_pipe.sv
// Bench for addsat_pipe: directed vectors from the block's worked examples,
// backpressure, status counter/sticky, reset mid-flight and a random run.
// Expected beats go into a scoreboard queue; a monitor pops on transfer.
module tb_addsat_pipe;
    localparam int W    = 16;
    localparam int L    = 8;
    localparam int CW   = 4;
    localparam int NL   = W / L;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0]  r;
        logic          co;
        logic [NL-1:0] flag;
    } exp_t;

    logic clk;
    logic reset;
    logic [1:0] rmode = 2'd1;   // 0: out_ready low, 1: high, 2: random
    logic       rbit  = 1'b1;

    addsat_pipe_if #(.WIDTH(W), .LANE(L), .CNTW(CW)) bus ();

    addsat_pipe #(.WIDTH(W), .LANE(L), .CNTW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.out_ready = (rmode == 2'd2) ? rbit : rmode[0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #2;
        rbit = ($urandom_range(0, 3) != 0);
    end

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   accepted = 0;
    logic [NL-1:0] m_sticky = '0;
    int   m_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one segment of the add, done with plain signed arithmetic
    function automatic void seg_add(input longint av, input longint bv, input int ci,
                                    input int w, input bit sat_en,
                                    output longint res, output bit flg, output bit cy);
        longint lim = longint'(1) << w;
        longint sb_ = (bv >= lim / 2) ? bv - lim : bv;
        longint t   = av + sb_ + ci;
        longint raw = av + bv + ci;
        cy  = (raw >= lim);
        flg = sat_en && (t >= lim || t < 0);
        res = flg ? ((t < 0) ? 0 : lim - 1) : (raw % lim);
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sat, input logic split);
        exp_t e;
        longint res;
        bit flg, cy;
        e.r = '0; e.co = 1'b0; e.flag = '0;
        if (split) begin
            for (int i = 0; i < NL; i++) begin
                seg_add(longint'(a[i*L +: L]), longint'(b[i*L +: L]),
                        (i == 0) ? int'(cin) : 0, L, sat, res, flg, cy);
                e.r[i*L +: L] = L'(res);
                e.flag[i] = flg;
                e.co = cy;
            end
        end else begin
            seg_add(longint'(a), longint'(b), int'(cin), W, sat, res, flg, cy);
            e.r    = W'(res);
            e.co   = cy;
            e.flag = {NL{flg}};
        end
        return e;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // present a beat (caller sits just after a rising edge), wait for accept
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sat, input logic split, input bit has_exp, input exp_t ex);
        exp_t e;
        int n = 0;
        e = has_exp ? ex : model(a, b, cin, sat, split);
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sat = sat; bus.split = split;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            sb.push_back(e);
            accepted++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        sync();
    endtask

    // monitor: status against model every cycle, result against queue head
    always begin
        @(negedge clk);
        if (reset) begin
            sb.delete();
            m_sticky = '0;
            m_cnt    = 0;
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_r", 64'(bus.r), 64'd0);
            chk("rst_co", 64'(bus.co), 64'd0);
            chk("rst_satflag", 64'(bus.satflag), 64'd0);
            chk("rst_sticky", 64'(bus.sat_sticky), 64'd0);
            chk("rst_count", 64'(bus.sat_count), 64'd0);
        end else begin
            bit   xf;
            exp_t e;
            xf = 1'b0;
            e.r = '0; e.co = 1'b0; e.flag = '0;
            chk("sat_sticky", 64'(bus.sat_sticky), 64'(m_sticky));
            chk("sat_count", 64'(bus.sat_count), 64'(m_cnt));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb[0];
                    chk("r", 64'(bus.r), 64'(e.r));
                    chk("co", 64'(bus.co), 64'(e.co));
                    chk("satflag", 64'(bus.satflag), 64'(e.flag));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        xf = 1'b1;
                    end
                end
            end
            if (bus.clr_status) begin
                m_sticky = xf ? e.flag : '0;
                m_cnt    = (xf && (|e.flag)) ? 1 : 0;
            end else if (xf) begin
                m_sticky = m_sticky | e.flag;
                if ((|e.flag) && m_cnt < CMAX) m_cnt++;
            end
        end
    end

    // directed vectors with hand-worked results
    typedef struct {
        logic [W-1:0] a, b;
        logic cin, sat, split;
        exp_t e;
    } vec_t;

    vec_t vt[10];
    exp_t none;

    initial begin
        vt[0] = '{16'hFFF0, 16'h0020, 1'b0, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 2'b11}};
        vt[1] = '{16'h0010, 16'hFFE0, 1'b0, 1'b1, 1'b0, '{16'h0000, 1'b0, 2'b11}};
        vt[2] = '{16'h0010, 16'hFFE0, 1'b0, 1'b0, 1'b0, '{16'hFFF0, 1'b0, 2'b00}};
        vt[3] = '{16'hF010, 16'h20E0, 1'b0, 1'b1, 1'b1, '{16'hFF00, 1'b1, 2'b11}};
        vt[4] = '{16'hF010, 16'h20E0, 1'b0, 1'b0, 1'b1, '{16'h10F0, 1'b1, 2'b00}};
        vt[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1, '{16'h0000, 1'b0, 2'b00}};
        vt[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, '{16'h0100, 1'b0, 2'b00}};
        vt[7] = '{16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b0, '{16'h1233, 1'b1, 2'b00}};
        vt[8] = '{16'h00F0, 16'h0020, 1'b0, 1'b1, 1'b1, '{16'h00FF, 1'b0, 2'b01}};
        vt[9] = '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 2'b11}};
        none = '{16'h0, 1'b0, 2'b00};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.cin = 1'b0; bus.sat = 1'b0; bus.split = 1'b0; bus.clr_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sync();
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
        chk("out_valid_after_reset", 64'(bus.out_valid), 64'd0);

        // directed vectors back to back, modes changing every beat
        for (int i = 0; i < 10; i++)
            send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sat, vt[i].split, 1'b1, vt[i].e);
        drain();

        // latency: accept -> idle S2 one cycle -> result
        send(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, none);
        chk("latency_c1_out_valid", 64'(bus.out_valid), 64'd0);
        sync();
        chk("latency_c2_out_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // backpressure: five beats into a stalled consumer
        rmode = 2'd0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(16'(i * 16'h1111), 16'(16'hF0F0 - i), 1'(i), 1'b1, 1'(i % 2), 1'b0, none);
            end
            begin
                repeat (6) @(posedge clk);
                #3;
                chk("bp_accepted", 64'(accepted), 64'd2);
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
                rmode = 2'd1;
            end
        join
        drain();
        chk("bp_total", 64'(accepted), 64'd5);

        // counter saturates
        for (int i = 0; i < 20; i++)
            send(16'hFFF0, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, none);
        drain();
        chk("count_hold", 64'(bus.sat_count), 64'hF);

        // clear coincident with a lane-0-only saturating transfer
        send(16'h00F0, 16'h0020, 1'b0, 1'b1, 1'b1, 1'b0, none);
        sync();
        bus.clr_status = 1'b1;
        sync();
        bus.clr_status = 1'b0;
        chk("clr_xfer_count", 64'(bus.sat_count), 64'd1);
        chk("clr_xfer_sticky", 64'(bus.sat_sticky), 64'b01);

        // random run with random backpressure and occasional clears
        rmode = 2'd2;
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            bus.clr_status = ($urandom_range(0, 15) == 0);
            send(ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, none);
            bus.clr_status = 1'b0;
            if ($urandom_range(0, 7) == 0) sync();
        end
        rmode = 2'd1;
        drain();

        // reset with two beats in flight
        rmode = 2'd0;
        send(16'hFFF0, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, none);
        send(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, none);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_r", 64'(bus.r), 64'd0);
        chk("midrst_satflag", 64'(bus.satflag), 64'd0);
        chk("midrst_count", 64'(bus.sat_count), 64'd0);
        repeat (2) @(negedge clk);
        sync();
        reset = 1'b0;
        rmode = 2'd1;
        repeat (6) sync();
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_queue", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
